mem_access: RTL and testbench

Memory-access stage of the RV32I pipeline and the consumer of the execute stage's registered outputs. It takes the execute result (`ex_val`: ALU result or effective address) together with `store_val`, `insn_type`/`insn_sub_type` and `rd_ex`. It runs load/store transactions on the data-memory request/acknowledge interface and returns the MEM-stage bypass pair (`bp_mem_reg`, `bp_mem_val`) to execute. It stalls the pipeline while a memory transaction is outstanding, and presents the writeback triple to the register file.

---
 rtl/mem_access.sv | 167 ++++++++++++++++
 tb/tb_mem_access.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// rtl/mem_access.sv - RV32I memory-access stage: load/store sequencing, writeback and MEM bypass
module mem_access #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          insn_valid,
  input  logic [3:0]    insn_type,
  input  logic [3:0]    insn_sub_type,
  input  logic [4:0]    rd_ex,
  input  logic [31:0]   ex_val,
  input  logic [31:0]   store_val,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [3:0]    dmem_be,
  output logic [31:0]   dmem_wdata,
  input  logic          dmem_ack,
  input  logic [31:0]   dmem_rdata,
  output logic          mem_stall,
  output logic          wb_valid,
  output logic [4:0]    wb_reg,
  output logic [31:0]   wb_val,
  output logic [4:0]    bp_mem_reg,
  output logic [31:0]   bp_mem_val,
  output logic          misalign_err
);

  localparam logic [3:0] T_AR = 4'd0;
  localparam logic [3:0] T_L  = 4'd1;
  localparam logic [3:0] T_S  = 4'd2;
  localparam logic [3:0] T_DB = 4'd3;
  localparam logic [3:0] T_IB = 4'd4;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      state;
  logic [4:0]  cap_rd;
  logic [1:0]  cap_off;
  logic [1:0]  cap_size;
  logic        cap_zext;
  logic        cap_load;

  logic [1:0]  in_size;
  logic [1:0]  in_off;
  logic        in_mem;
  logic        in_alu;
  logic        in_legal;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] lane;
  logic [31:0] load_val;
  logic        sub_unused;

  assign sub_unused = insn_sub_type[3];
  assign mem_stall  = (state == REQ);

  always_comb begin
    in_size  = insn_sub_type[1:0];
    in_off   = ex_val[1:0];
    in_mem   = (insn_type == T_L) || (insn_type == T_S);
    in_alu   = (insn_type == T_AR) || (insn_type == T_DB) || (insn_type == T_IB);
    in_legal = (in_size == 2'd0) ||
               ((in_size == 2'd1) && !in_off[0]) ||
               ((in_size == 2'd2) && (in_off == 2'd0));
    be_c     = 4'b1111;
    wdata_c  = store_val;
    case (in_size)
      2'd0: begin
        be_c    = 4'b0001 << in_off;
        wdata_c = {4{store_val[7:0]}};
      end
      2'd1: begin
        be_c    = in_off[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{store_val[15:0]}};
      end
      default: ;
    endcase

    // Response lane is selected by the captured address, not the live ex_val.
    lane     = dmem_rdata >> {cap_off, 3'b000};
    load_val = lane;
    case (cap_size)
      2'd0: load_val = cap_zext ? {24'd0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      2'd1: load_val = cap_zext ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cap_rd       <= 5'd0;
      cap_off      <= 2'd0;
      cap_size     <= 2'd0;
      cap_zext     <= 1'b0;
      cap_load     <= 1'b0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_be      <= 4'd0;
      dmem_wdata   <= 32'd0;
      wb_valid     <= 1'b0;
      wb_reg       <= 5'd0;
      wb_val       <= 32'd0;
      bp_mem_reg   <= 5'd0;
      bp_mem_val   <= 32'd0;
      misalign_err <= 1'b0;
    end else begin
      case (state)
        REQ: begin
          if (dmem_ack) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= 4'd0;
            dmem_wdata <= 32'd0;
            if (cap_load) begin
              state      <= RESP;
              wb_valid   <= (cap_rd != 5'd0);
              wb_reg     <= cap_rd;
              wb_val     <= load_val;
              bp_mem_reg <= cap_rd;
              bp_mem_val <= (cap_rd != 5'd0) ? load_val : 32'd0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          // RESP also accepts input: upstream was released on the ack edge.
          state        <= IDLE;
          wb_valid     <= 1'b0;
          wb_reg       <= 5'd0;
          wb_val       <= 32'd0;
          bp_mem_reg   <= 5'd0;
          bp_mem_val   <= 32'd0;
          misalign_err <= 1'b0;
          if (insn_valid && in_alu) begin
            wb_valid   <= (rd_ex != 5'd0);
            wb_reg     <= rd_ex;
            wb_val     <= ex_val;
            bp_mem_reg <= rd_ex;
            bp_mem_val <= (rd_ex != 5'd0) ? ex_val : 32'd0;
          end else if (insn_valid && in_mem) begin
            if (in_legal) begin
              state      <= REQ;
              cap_rd     <= rd_ex;
              cap_off    <= in_off;
              cap_size   <= in_size;
              cap_zext   <= insn_sub_type[2];
              cap_load   <= (insn_type == T_L);
              dmem_req   <= 1'b1;
              dmem_we    <= (insn_type == T_S);
              dmem_addr  <= AW'({ex_val[31:2], 2'b00});
              dmem_be    <= be_c;
              dmem_wdata <= wdata_c;
            end else begin
              misalign_err <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - randomized self-checking bench for mem_access against a transaction model
module tb_mem_access;

  localparam logic [3:0] T_AR = 4'd0;
  localparam logic [3:0] T_L  = 4'd1;
  localparam logic [3:0] T_S  = 4'd2;
  localparam logic [3:0] T_DB = 4'd3;
  localparam logic [3:0] T_IB = 4'd4;
  localparam logic [3:0] T_BUB = 4'hF;

  logic        clk = 1'b0;
  logic        rst;
  logic        insn_valid;
  logic [3:0]  insn_type, insn_sub_type;
  logic [4:0]  rd_ex;
  logic [31:0] ex_val, store_val;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic        mem_stall, wb_valid, misalign_err;
  logic [4:0]  wb_reg, bp_mem_reg;
  logic [31:0] wb_val, bp_mem_val;

  always #5 clk = ~clk;

  mem_access #(.AW(32)) dut (
    .clk(clk), .rst(rst), .insn_valid(insn_valid), .insn_type(insn_type),
    .insn_sub_type(insn_sub_type), .rd_ex(rd_ex), .ex_val(ex_val), .store_val(store_val),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_val(wb_val),
    .bp_mem_reg(bp_mem_reg), .bp_mem_val(bp_mem_val), .misalign_err(misalign_err)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic        e_req, e_we, e_stall, e_wbv, e_mis;
  logic [31:0] e_addr, e_wdata, e_wbval, e_bpval;
  logic [3:0]  e_be;
  logic [4:0]  e_wbreg, e_bpreg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic set_idle();
    e_req = 0; e_we = 0; e_stall = 0; e_wbv = 0; e_mis = 0;
    e_addr = 0; e_wdata = 0; e_wbval = 0; e_bpval = 0; e_be = 0;
    e_wbreg = 0; e_bpreg = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_stall", {31'd0, mem_stall}, {31'd0, e_stall});
      chk("dmem_req", {31'd0, dmem_req}, {31'd0, e_req});
      if (e_req) begin
        chk("dmem_we", {31'd0, dmem_we}, {31'd0, e_we});
        chk("dmem_addr", dmem_addr, e_addr);
        chk("dmem_be", {28'd0, dmem_be}, {28'd0, e_be});
        chk("dmem_wdata", dmem_wdata, e_wdata);
      end
      chk("wb_valid", {31'd0, wb_valid}, {31'd0, e_wbv});
      if (e_wbv) begin
        chk("wb_reg", {27'd0, wb_reg}, {27'd0, e_wbreg});
        chk("wb_val", wb_val, e_wbval);
      end
      chk("bp_mem_reg", {27'd0, bp_mem_reg}, {27'd0, e_bpreg});
      chk("bp_mem_val", bp_mem_val, e_bpval);
      chk("misalign_err", {31'd0, misalign_err}, {31'd0, e_mis});
    end
  end

  // Byte i is written when it falls inside [off, off+nb).
  function automatic logic [3:0] m_be(input int off, input int nb);
    logic [3:0] b;
    for (int i = 0; i < 4; i++) b[i] = (i >= off) && (i < off + nb);
    return b;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] sv, input int nb);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = sv[8*(i % nb) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd, input int off, input int nb,
                                         input bit zext);
    logic [31:0] v = 32'd0;
    for (int j = 0; j < nb; j++) v[8*j +: 8] = rd[8*(off + j) +: 8];
    if (!zext && nb < 4 && v[8*nb - 1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
    return v;
  endfunction

  // Issues one instruction and walks the model through every cycle it occupies.
  task automatic run(input logic [3:0] typ, input logic [3:0] sub, input logic [4:0] rd,
                     input logic [31:0] ev, input logic [31:0] sv, input int k,
                     input logic [31:0] rdata, input bit lit_en, input logic [31:0] lit);
    int nb, off;
    bit is_mem, legal;
    insn_valid = (typ != T_BUB); insn_type = typ; insn_sub_type = sub;
    rd_ex = rd; ex_val = ev; store_val = sv;
    dmem_ack = 1'($urandom % 2); dmem_rdata = $urandom;
    @(posedge clk); #1;
    insn_valid = 0; dmem_ack = 0;
    off = int'(ev % 4);
    nb = (sub[1:0] == 2'd0) ? 1 : (sub[1:0] == 2'd1) ? 2 : (sub[1:0] == 2'd2) ? 4 : 0;
    is_mem = (typ == T_L) || (typ == T_S);
    legal = (nb != 0) && ((ev % nb) == 0);
    set_idle();
    if (!is_mem) begin
      if (typ == T_AR || typ == T_DB || typ == T_IB) begin
        e_wbv = (rd != 0); e_wbreg = rd; e_wbval = ev;
        e_bpreg = rd; e_bpval = (rd != 0) ? ev : 32'd0;
      end
      return;
    end
    if (!legal) begin
      e_mis = 1;
      return;
    end
    for (int i = 0; i <= k; i++) begin
      e_req = 1; e_stall = 1; e_we = (typ == T_S);
      e_addr = ev - off; e_be = m_be(off, nb); e_wdata = m_wdata(sv, nb);
      if (lit_en && typ == T_S && i == 0) chk("lit_store_wdata", dmem_wdata, lit);
      insn_valid = 1'($urandom % 2); insn_type = 4'($urandom % 5); insn_sub_type = 4'($urandom);
      rd_ex = 5'($urandom); ex_val = $urandom; store_val = $urandom;
      dmem_ack = (i == k);
      dmem_rdata = (i == k) ? rdata : $urandom;
      @(posedge clk); #1;
    end
    insn_valid = 0; dmem_ack = 0;
    set_idle();
    if (typ == T_L) begin
      e_wbv = (rd != 0); e_wbreg = rd; e_wbval = m_load(rdata, off, nb, sub[2]);
      e_bpreg = rd; e_bpval = (rd != 0) ? e_wbval : 32'd0;
      if (lit_en) chk("lit_load_wb_val", wb_val, lit);
    end
  endtask

  initial begin
    rst = 1; insn_valid = 0; insn_type = 0; insn_sub_type = 0; rd_ex = 0;
    ex_val = 0; store_val = 0; dmem_ack = 0; dmem_rdata = 0;
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    chk("rst_dmem_be", {28'd0, dmem_be}, 32'd0);
    chk("rst_dmem_wdata", dmem_wdata, 32'd0);
    chk("rst_mem_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_bp_mem_reg", {27'd0, bp_mem_reg}, 32'd0);
    chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
    rst = 0;
    chk_en = 1;

    run(T_AR, 4'd0, 5'd5, 32'h1234, 32'd0, 0, 32'd0, 0, 32'd0);
    chk("ar_bp_reg_lit", {27'd0, bp_mem_reg}, 32'd5);
    run(T_L, 4'b0000, 5'd7, 32'h103, 32'd0, 2, 32'h80FF_0000, 1, 32'hFFFF_FF80);
    run(T_L, 4'b0101, 5'd8, 32'h202, 32'd0, 0, 32'hBEEF_1234, 1, 32'h0000_BEEF);
    run(T_S, 4'b0001, 5'd9, 32'h206, 32'hAAAA_5678, 1, 32'd0, 1, 32'h5678_5678);
    run(T_L, 4'b0010, 5'd3, 32'h301, 32'd0, 0, 32'd0, 0, 32'd0);
    chk("lw_misalign_lit", {31'd0, misalign_err}, 32'd1);
    run(T_L, 4'b0011, 5'd3, 32'h300, 32'd0, 0, 32'd0, 0, 32'd0);
    run(T_DB, 4'd0, 5'd0, 32'h4444, 32'd0, 0, 32'd0, 0, 32'd0);
    run(T_BUB, 4'd0, 5'd1, 32'h1, 32'd0, 0, 32'd0, 0, 32'd0);

    for (int n = 0; n < 400; n++) begin
      logic [3:0] typ;
      logic [31:0] ev;
      case ($urandom % 6)
        0: typ = T_AR;
        1: typ = T_L;
        2: typ = T_S;
        3: typ = T_DB;
        4: typ = T_IB;
        default: typ = T_BUB;
      endcase
      ev = ($urandom % 4 == 0) ? $urandom : ($urandom % 4096);
      run(typ, 4'($urandom), 5'($urandom), ev, $urandom, int'($urandom % 4), $urandom, 0, 32'd0);
    end

    // Abandon a word load mid-request with an asynchronous reset.
    insn_valid = 1; insn_type = T_L; insn_sub_type = 4'b0010; rd_ex = 5'd4;
    ex_val = 32'h400; dmem_ack = 0;
    @(posedge clk); #1;
    insn_valid = 0;
    set_idle();
    e_req = 1; e_stall = 1; e_addr = 32'h400; e_be = 4'hF; e_wdata = dmem_wdata;
    @(posedge clk); #1;
    chk("req_before_rst", {31'd0, dmem_req}, 32'd1);
    chk_en = 0;
    #1 rst = 1;
    #1;
    chk("rst_async_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_async_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    rst = 0;
    set_idle();
    chk_en = 1;
    run(T_AR, 4'd0, 5'd6, 32'hCAFE_0001, 32'd0, 0, 32'd0, 0, 32'd0);
    chk("post_rst_wb_val_lit", wb_val, 32'hCAFE_0001);
    run(T_BUB, 4'd0, 5'd0, 32'd0, 32'd0, 0, 32'd0, 0, 32'd0);
    @(posedge clk); #1;
    chk_en = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
